// File: rtl/mini_cpu_pkg.sv
// Shared definitions for the mini CPU executor and the LCD driver:
// opcodes, FSM encoding, instruction field positions and data width.
package mini_cpu_pkg;

    localparam int DATA_W  = 16;
    localparam int INSTR_W = 18;
    localparam int NREGS   = 16;

    localparam int OP_LSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int RS1_LSB = 7;
    localparam int RS2_LSB = 3;
    localparam int IMM7_W  = 7;
    localparam int IMM11_W = 11;

    localparam logic [2:0] OP_LOAD    = 3'd0;
    localparam logic [2:0] OP_ADD     = 3'd1;
    localparam logic [2:0] OP_ADDI    = 3'd2;
    localparam logic [2:0] OP_SUB     = 3'd3;
    localparam logic [2:0] OP_SUBI    = 3'd4;
    localparam logic [2:0] OP_MUL     = 3'd5;
    localparam logic [2:0] OP_CLEAR   = 3'd6;
    localparam logic [2:0] OP_DISPLAY = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MUL_WAIT,
        S_REPORT
    } state_t;

endpackage

// File: rtl/mini_cpu_mul.sv
// Iterative shift-add multiplier, one partial product per cycle.
// Keeps only the low W bits of the product.
module mini_cpu_mul
    import mini_cpu_pkg::*;
#(
    parameter int W      = DATA_W,
    parameter int CYCLES = W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] product
);

    localparam int CNT_W = $clog2(CYCLES + 1);

    logic [W-1:0]     acc;
    logic [W-1:0]     mcand;
    logic [W-1:0]     mplier;
    logic [CNT_W-1:0] cnt;
    logic             run;

    // The start edge already folds in bit 0, so done lands after CYCLES edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            run    <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                acc    <= b[0] ? a : '0;
                mcand  <= a << 1;
                mplier <= b >> 1;
                cnt    <= CNT_W'(CYCLES - 1);
                run    <= 1'b1;
            end else if (run) begin
                if (mplier[0])
                    acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign product = acc;

endmodule

// File: rtl/mini_cpu_exec.sv
// Register file plus multi-cycle executor feeding the LCD driver.
// Define MINI_CPU_MUL_EN to build the iterative multiplier for MUL.
module mini_cpu_exec
    import mini_cpu_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int MUL_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              power_en,
    input  logic              send_strobe,
    input  logic [17:0]       instr,
    output logic [3:0]        result_opcode,
    output logic [3:0]        result_dest,
    output logic [DATA_W-1:0] result_value,
    output logic              result_valid,
    output logic              busy
);

    // Empty block exists only to flag an invalid configuration.
    if (MUL_CYCLES != DATA_W) begin : g_mul_cycles_ne_data_w
    end

    state_t              state;
    logic [INSTR_W-1:0]  ir;
    logic [DATA_W-1:0]   regs [NREGS];
    logic [DATA_W-1:0]   opa;
    logic [DATA_W-1:0]   opb;
    logic [DATA_W-1:0]   res_q;
    logic [3:0]          dest_q;
    logic [DATA_W-1:0]   alu;

    logic [2:0]          op;
    logic [3:0]          rd;
    logic [3:0]          rs1;
    logic [3:0]          rs2;
    logic [DATA_W-1:0]   imm7;
    logic [DATA_W-1:0]   imm11;

    assign op    = ir[OP_LSB +: 3];
    assign rd    = ir[RD_LSB +: 4];
    assign rs1   = ir[RS1_LSB +: 4];
    assign rs2   = ir[RS2_LSB +: 4];
    assign imm7  = {{(DATA_W-IMM7_W){ir[IMM7_W-1]}},
                    ir[IMM7_W-1:0]};
    assign imm11 = {{(DATA_W-IMM11_W){ir[IMM11_W-1]}},
                    ir[IMM11_W-1:0]};

    assign busy = (state != S_IDLE);

    always_comb begin
        alu = '0;
        case (op)
            OP_LOAD:           alu = opa;
            OP_ADD, OP_ADDI:   alu = opa + opb;
            OP_SUB, OP_SUBI:   alu = opa - opb;
            OP_DISPLAY:        alu = opa;
            default:           alu = '0;
        endcase
    end

`ifdef MINI_CPU_MUL_EN
    logic              mul_done;
    logic [DATA_W-1:0] mul_p;

    mini_cpu_mul #(
        .W      (DATA_W),
        .CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (state == S_EXEC && op == OP_MUL),
        .a       (opa),
        .b       (opb),
        .done    (mul_done),
        .product (mul_p)
    );
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            ir            <= '0;
            opa           <= '0;
            opb           <= '0;
            res_q         <= '0;
            dest_q        <= '0;
            result_opcode <= '0;
            result_dest   <= '0;
            result_value  <= '0;
            result_valid  <= 1'b0;
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else begin
            result_valid <= 1'b0;
            // Power loss abandons the instruction; registers are kept.
            if (state != S_IDLE && !power_en) begin
                state <= S_IDLE;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (send_strobe && power_en) begin
                            ir    <= instr;
                            state <= S_DECODE;
                        end
                    end
                    S_DECODE: begin
                        if (op == OP_LOAD)
                            opa <= imm11;
                        else if (op == OP_DISPLAY)
                            opa <= regs[rd];
                        else
                            opa <= regs[rs1];
                        if (op == OP_ADDI || op == OP_SUBI)
                            opb <= imm7;
                        else
                            opb <= regs[rs2];
                        state <= S_EXEC;
                    end
                    S_EXEC: begin
                        res_q  <= alu;
                        dest_q <= (op == OP_CLEAR) ? 4'd0 : rd;
                        if (op == OP_CLEAR) begin
                            for (int i = 0; i < NREGS; i++)
                                regs[i] <= '0;
                        end else if (op <= OP_SUBI) begin
                            regs[rd] <= alu;
                        end
`ifdef MINI_CPU_MUL_EN
                        state <= (op == OP_MUL) ? S_MUL_WAIT
                                                : S_REPORT;
`else
                        state <= S_REPORT;
`endif
                    end
                    S_MUL_WAIT: begin
`ifdef MINI_CPU_MUL_EN
                        if (mul_done) begin
                            regs[rd] <= mul_p;
                            res_q    <= mul_p;
                            state    <= S_REPORT;
                        end
`else
                        state <= S_IDLE;
`endif
                    end
                    S_REPORT: begin
                        result_opcode <= {1'b0, op};
                        result_dest   <= dest_q;
                        result_value  <= res_q;
                        result_valid  <= 1'b1;
                        state         <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mini_cpu_exec.sv
// Randomised and directed bench for mini_cpu_exec against a
// behavioural register-file model.
module tb_mini_cpu_exec;

`ifdef MINI_CPU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    localparam int MUL_CYCLES = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        power_en = 1'b1;
    logic        send_strobe = 1'b0;
    logic [17:0] instr = '0;
    logic [3:0]  result_opcode;
    logic [3:0]  result_dest;
    logic [15:0] result_value;
    logic        result_valid;
    logic        busy;

    int n_checks = 0;
    int n_pass = 0;

    logic [15:0] mregs [16];

    mini_cpu_exec #(
        .DATA_W     (16),
        .MUL_CYCLES (MUL_CYCLES)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .power_en      (power_en),
        .send_strobe   (send_strobe),
        .instr         (instr),
        .result_opcode (result_opcode),
        .result_dest   (result_dest),
        .result_value  (result_value),
        .result_valid  (result_valid),
        .busy          (busy)
    );

    always #10 clk = ~clk;

    // Reference: architectural effect of one instruction.
    task automatic model(input logic [17:0] i,
                         output logic [3:0] eop,
                         output logic [3:0] edest,
                         output logic [15:0] ev,
                         output int elat);
        int o;
        logic [3:0] d;
        longint a, b, im7, im11, v;
        logic signed [6:0] s7;
        logic signed [10:0] s11;
        bit wr;
        o = int'(i[17:15]);
        d = i[14:11];
        a = mregs[i[10:7]];
        b = mregs[i[6:3]];
        s7 = i[6:0];
        s11 = i[10:0];
        im7 = s7;
        im11 = s11;
        v = 0;
        wr = 1;
        edest = d;
        elat = 3;
        case (o)
            0: v = im11;
            1: v = a + b;
            2: v = a + im7;
            3: v = a - b;
            4: v = a - im7;
            5: begin
                if (MUL_EN) begin
                    v = a * b;
                    elat = 3 + MUL_CYCLES;
                end else begin
                    v = 0;
                    wr = 0;
                end
            end
            6: begin
                foreach (mregs[k]) mregs[k] = '0;
                wr = 0;
                edest = 0;
                v = 0;
            end
            default: begin
                v = mregs[d];
                wr = 0;
            end
        endcase
        ev = v[15:0];
        if (wr) mregs[d] = ev;
        eop = 4'(o);
    endtask

    // Issue one strobe, optionally a second one inj_at cycles later.
    task automatic run(input logic [17:0] ins,
                       input int inj_at,
                       input logic [17:0] inj_ins,
                       output int lat,
                       output int pulses,
                       output logic [3:0] gop,
                       output logic [3:0] gdest,
                       output logic [15:0] gval);
        @(posedge clk); #1;
        instr = ins;
        send_strobe = 1'b1;
        @(posedge clk); #1;
        send_strobe = 1'b0;
        lat = -1;
        pulses = 0;
        gop = 'x;
        gdest = 'x;
        gval = 'x;
        for (int k = 1; k <= 40; k++) begin
            if (inj_at > 0 && k == inj_at + 1) begin
                instr = inj_ins;
                send_strobe = 1'b1;
            end
            @(posedge clk); #1;
            send_strobe = 1'b0;
            if (result_valid) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    gop = result_opcode;
                    gdest = result_dest;
                    gval = result_value;
                end
            end
            if (lat > 0 && k >= lat + 4) break;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        power_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (result_valid !== 1'b0)
            $display("FAIL rst_valid got %b exp 0", result_valid);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0)
            $display("FAIL rst_busy got %b exp 0", busy);
        else n_pass++;
        n_checks++;
        if ({result_opcode, result_dest, result_value} !== 24'h0)
            $display("FAIL rst_outs got %h exp 0",
                     {result_opcode, result_dest, result_value});
        else n_pass++;
        reset = 1'b0;
        foreach (mregs[k]) mregs[k] = '0;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0)
            $display("FAIL post_rst_busy got %b exp 0", busy);
        else n_pass++;
    endtask

    task automatic test_load_addi;
        logic [17:0] ins;
        logic [3:0] eop, ed, gop, gd;
        logic [15:0] ev, gv;
        int el, lat, np;
        ins = 18'b000_0011_00000000101;
        model(ins, eop, ed, ev, el);
        run(ins, 0, '0, lat, np, gop, gd, gv);
        n_checks++;
        if (lat !== el) $display("FAIL load_lat got %0d exp %0d", lat, el);
        else n_pass++;
        n_checks++;
        if (gop !== 4'd0) $display("FAIL load_op got %0d exp 0", gop);
        else n_pass++;
        n_checks++;
        if (gd !== 4'd3) $display("FAIL load_dest got %0d exp 3", gd);
        else n_pass++;
        n_checks++;
        if (gv !== 16'h0005) $display("FAIL load_val got %h exp 0005", gv);
        else n_pass++;
        ins = {3'b010, 4'd4, 4'd3, 7'h79};
        model(ins, eop, ed, ev, el);
        run(ins, 0, '0, lat, np, gop, gd, gv);
        n_checks++;
        if (gv !== 16'hFFFE) $display("FAIL addi_val got %h exp FFFE", gv);
        else n_pass++;
        n_checks++;
        if (gd !== 4'd4) $display("FAIL addi_dest got %0d exp 4", gd);
        else n_pass++;
        n_checks++;
        if (lat !== 3) $display("FAIL addi_lat got %0d exp 3", lat);
        else n_pass++;
    endtask

    task automatic test_mul;
        logic [17:0] ins;
        logic [3:0] eop, ed, gop, gd;
        logic [15:0] ev, gv;
        int el, lat, np;
        ins = {3'b101, 4'd5, 4'd3, 4'd4, 3'b000};
        model(ins, eop, ed, ev, el);
        run(ins, 0, '0, lat, np, gop, gd, gv);
        n_checks++;
        if (lat !== el) $display("FAIL mul_lat got %0d exp %0d", lat, el);
        else n_pass++;
        n_checks++;
        if (gv !== ev) $display("FAIL mul_val got %h exp %h", gv, ev);
        else n_pass++;
        n_checks++;
        if (gop !== 4'd5 || gd !== 4'd5)
            $display("FAIL mul_opdest got %0d/%0d exp 5/5", gop, gd);
        else n_pass++;
        ins = {3'b111, 4'd5, 11'd0};
        model(ins, eop, ed, ev, el);
        run(ins, 0, '0, lat, np, gop, gd, gv);
        n_checks++;
        if (gv !== ev) $display("FAIL mul_r5 got %h exp %h", gv, ev);
        else n_pass++;
    endtask

    task automatic test_mul_wrap;
        logic [17:0] ins;
        logic [3:0] eop, ed, gop, gd;
        logic [15:0] ev, gv;
        int el, lat, np;
        for (int r = 1; r <= 2; r++) begin
            ins = {3'b000, 4'(r), 11'h100};
            model(ins, eop, ed, ev, el);
            run(ins, 0, '0, lat, np, gop, gd, gv);
            n_checks++;
            if (gv !== 16'h0100)
                $display("FAIL wrap_load%0d got %h exp 0100", r, gv);
            else n_pass++;
        end
        ins = {3'b101, 4'd8, 4'd1, 4'd2, 3'b000};
        model(ins, eop, ed, ev, el);
        run(ins, 0, '0, lat, np, gop, gd, gv);
        n_checks++;
        if (gv !== 16'h0000) $display("FAIL wrap_val got %h exp 0000", gv);
        else n_pass++;
        n_checks++;
        if (lat !== el) $display("FAIL wrap_lat got %0d exp %0d", lat, el);
        else n_pass++;
    endtask

    task automatic test_drop_strobe;
        logic [17:0] ins, inj;
        logic [3:0] eop, ed, gop, gd;
        logic [15:0] ev, gv;
        int el, lat, np;
        ins = MUL_EN ? {3'b101, 4'd7, 4'd3, 4'd4, 3'b000}
                     : {3'b001, 4'd7, 4'd3, 4'd4, 3'b000};
        inj = {3'b000, 4'd6, 11'h3FF};
        model(ins, eop, ed, ev, el);
        run(ins, MUL_EN ? 5 : 1, inj, lat, np, gop, gd, gv);
        n_checks++;
        if (np !== 1) $display("FAIL drop_pulses got %0d exp 1", np);
        else n_pass++;
        n_checks++;
        if (gv !== ev) $display("FAIL drop_val got %h exp %h", gv, ev);
        else n_pass++;
        ins = {3'b111, 4'd6, 11'd0};
        model(ins, eop, ed, ev, el);
        run(ins, 0, '0, lat, np, gop, gd, gv);
        n_checks++;
        if (gv !== ev) $display("FAIL drop_r6 got %h exp %h", gv, ev);
        else n_pass++;
    endtask

    task automatic test_clear_display;
        logic [17:0] ins;
        logic [3:0] eop, ed, gop, gd;
        logic [15:0] ev, gv;
        int el, lat, np;
        ins = {3'b110, 15'h7FFF};
        model(ins, eop, ed, ev, el);
        run(ins, 0, '0, lat, np, gop, gd, gv);
        n_checks++;
        if (gop !== 4'd6 || gd !== 4'd0)
            $display("FAIL clr_opdest got %0d/%0d exp 6/0", gop, gd);
        else n_pass++;
        n_checks++;
        if (gv !== 16'h0) $display("FAIL clr_val got %h exp 0000", gv);
        else n_pass++;
        ins = {3'b111, 4'd3, 11'd0};
        model(ins, eop, ed, ev, el);
        run(ins, 0, '0, lat, np, gop, gd, gv);
        n_checks++;
        if (gop !== 4'd7 || gd !== 4'd3)
            $display("FAIL disp_opdest got %0d/%0d exp 7/3", gop, gd);
        else n_pass++;
        n_checks++;
        if (gv !== 16'h0) $display("FAIL disp_val got %h exp 0000", gv);
        else n_pass++;
    endtask

    task automatic test_power_loss;
        logic [17:0] ins;
        logic [3:0] eop, ed, gop, gd;
        logic [15:0] ev, gv;
        int el, lat, np, drop_at;
        ins = {3'b000, 4'd5, 11'h2A5};
        model(ins, eop, ed, ev, el);
        run(ins, 0, '0, lat, np, gop, gd, gv);
        ins = {3'b000, 4'd9, 11'd3};
        model(ins, eop, ed, ev, el);
        run(ins, 0, '0, lat, np, gop, gd, gv);
        // Not modelled: this instruction must be abandoned.
        ins = MUL_EN ? {3'b101, 4'd5, 4'd5, 4'd9, 3'b000}
                     : {3'b010, 4'd5, 4'd5, 7'd1};
        drop_at = MUL_EN ? 5 : 1;
        @(posedge clk); #1;
        instr = ins;
        send_strobe = 1'b1;
        @(posedge clk); #1;
        send_strobe = 1'b0;
        repeat (drop_at) begin
            @(posedge clk); #1;
        end
        power_en = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL pwr_busy got %b exp 0", busy);
        else n_pass++;
        np = 0;
        for (int k = 0; k < 25; k++) begin
            if (result_valid) np++;
            if (k == 3) power_en = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++;
        if (np !== 0) $display("FAIL pwr_pulses got %0d exp 0", np);
        else n_pass++;
        ins = {3'b111, 4'd5, 11'd0};
        model(ins, eop, ed, ev, el);
        run(ins, 0, '0, lat, np, gop, gd, gv);
        n_checks++;
        if (gv !== ev) $display("FAIL pwr_r5 got %h exp %h", gv, ev);
        else n_pass++;
    endtask

    task automatic test_power_off_strobe;
        int np;
        power_en = 1'b0;
        @(posedge clk); #1;
        instr = {3'b000, 4'd1, 11'h055};
        send_strobe = 1'b1;
        @(posedge clk); #1;
        send_strobe = 1'b0;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL off_busy got %b exp 0", busy);
        else n_pass++;
        np = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (result_valid) np++;
        end
        n_checks++;
        if (np !== 0) $display("FAIL off_pulses got %0d exp 0", np);
        else n_pass++;
        power_en = 1'b1;
    endtask

    task automatic test_random;
        logic [17:0] ins;
        logic [3:0] eop, ed, gop, gd;
        logic [15:0] ev, gv;
        logic [31:0] r;
        logic [2:0] o;
        int el, lat, np;
        for (int n = 0; n < 40; n++) begin
            r = $urandom();
            o = 3'($urandom_range(0, 7));
            if (o == 3'd6 && $urandom_range(0, 3) != 0) o = 3'd7;
            ins = {o, r[14:0]};
            model(ins, eop, ed, ev, el);
            run(ins, 0, '0, lat, np, gop, gd, gv);
            n_checks++;
            if (lat !== el)
                $display("FAIL rnd%0d_lat got %0d exp %0d", n, lat, el);
            else n_pass++;
            n_checks++;
            if (gop !== eop)
                $display("FAIL rnd%0d_op got %0d exp %0d", n, gop, eop);
            else n_pass++;
            n_checks++;
            if (gd !== ed)
                $display("FAIL rnd%0d_dest got %0d exp %0d", n, gd, ed);
            else n_pass++;
            n_checks++;
            if (gv !== ev)
                $display("FAIL rnd%0d_val got %h exp %h", n, gv, ev);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_exec;
        logic [17:0] ins;
        logic [3:0] eop, ed, gop, gd;
        logic [15:0] ev, gv;
        int el, lat, np;
        ins = {3'b000, 4'd9, 11'h123};
        model(ins, eop, ed, ev, el);
        run(ins, 0, '0, lat, np, gop, gd, gv);
        @(posedge clk); #1;
        instr = {3'b001, 4'd10, 4'd9, 4'd9, 3'b000};
        send_strobe = 1'b1;
        @(posedge clk); #1;
        send_strobe = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL mrst_busy got %b exp 0", busy);
        else n_pass++;
        n_checks++;
        if (result_valid !== 1'b0)
            $display("FAIL mrst_valid got %b exp 0", result_valid);
        else n_pass++;
        n_checks++;
        if ({result_opcode, result_dest, result_value} !== 24'h0)
            $display("FAIL mrst_outs got %h exp 0",
                     {result_opcode, result_dest, result_value});
        else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        foreach (mregs[k]) mregs[k] = '0;
        for (int r = 0; r < 16; r++) begin
            ins = {3'b111, 4'(r), 11'd0};
            model(ins, eop, ed, ev, el);
            run(ins, 0, '0, lat, np, gop, gd, gv);
            n_checks++;
            if (gv !== ev)
                $display("FAIL mrst_r%0d got %h exp %h", r, gv, ev);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_load_addi();
        test_mul();
        test_mul_wrap();
        test_drop_strobe();
        test_clear_display();
        test_power_loss();
        test_power_off_strobe();
        test_random();
        test_reset_mid_exec();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mini_cpu_exec.md
# mini_cpu_exec

Instruction executor that sits directly upstream of the LCD driver. It owns the 16×16-bit register file, latches one 18-bit instruction from the board switches per "send" strobe, and executes it in a small multi-cycle FSM. On completion it presents the opcode, destination register and result value to the LCD driver with a one-cycle valid pulse. MUL runs on an iterative shift-add unit.

## Interface
Parameters:
- `DATA_W`, default 16: register and result width.
- `MUL_CYCLES`, default 16: number of multiplier iterations; must equal `DATA_W`.

Ports:
- `clk`  in  1: system clock, 50 MHz.
- `reset`  in  1: asynchronous, active-high reset.
- `power_en`  in  1: level; the CPU is powered while high.
- `send_strobe`  in  1: one-cycle pulse from the upstream button edge detector.
- `instr`  in  18: switch word, sampled on the accepted strobe.
- `result_opcode`  out  4: executed opcode, zero-extended from 3 bits.
- `result_dest`  out  4: destination register, or the source register for DISPLAY.
- `result_value`  out  16: two's-complement result.
- `result_valid`  out  1: one-cycle pulse; all `result_*` outputs are stable while it is high and hold until the next pulse.
- `busy`  out  1: high in every state except IDLE.

## Operation
- Instruction fields:
  - `op = instr[17:15]`, `rd = instr[14:11]`, `rs1 = instr[10:7]`, `rs2 = instr[6:3]`.
  - `imm7 = instr[6:0]`, signed; `imm11 = instr[10:0]`, signed.
  - Both immediates are sign-extended to 16 bits.
- Opcodes:
  - 000 LOAD: `rd = imm11`.
  - 001 ADD: `rd = rs1 + rs2`.
  - 010 ADDI: `rd = rs1 + imm7`.
  - 011 SUB: `rd = rs1 - rs2`.
  - 100 SUBI: `rd = rs1 - imm7`.
  - 101 MUL: `rd = low 16 bits of rs1 * rs2`.
  - 110 CLEAR: all 16 registers become 0. Reports dest 0, value 0.
  - 111 DISPLAY: no write. Reports `result_dest = rd`, `result_value = R[rd]`.
- Arithmetic: all operations wrap modulo 2^16. There is no overflow detection. For MUL, the low half of the product is identical for signed and unsigned operands, so the multiplier is unsigned.
- FSM states: IDLE, DECODE, EXEC, MUL_WAIT, REPORT.
  - IDLE → DECODE when `send_strobe` is high and `power_en` is high. `instr` is latched on this edge.
  - DECODE: reads `rs1` and `rs2` (or the immediate) into operand registers. Next state is EXEC.
  - EXEC: non-MUL ops compute and write back in this cycle, then go to REPORT. MUL starts the multiplier and goes to MUL_WAIT.
  - MUL_WAIT: waits for multiplier `done`, then writes back and goes to REPORT.
  - REPORT: drives `result_valid` high for exactly one cycle, then returns to IDLE.
- Strobe handling:
  - A strobe while `busy` is dropped, not queued.
  - A strobe while `power_en` is low is ignored.
- Power loss: if `power_en` falls in any non-IDLE state, the FSM returns to IDLE on the next edge. The instruction is abandoned with no writeback and no valid pulse. Register contents are preserved.
- Register R0 is a normal, writable register.
- Reset values:
  - FSM in IDLE.
  - All registers 0.
  - `result_opcode`, `result_dest`, `result_value`, `result_valid` and `busy` all 0.
  - Multiplier cleared.
- Reset mid-operation: the instruction is aborted immediately and the block reaches the reset state above.

## Timing
- Define edge N as the edge that samples the accepted strobe.
- Non-MUL ops: writeback at edge N+2. `result_valid` is high in the cycle after edge N+3. Latency is 3 cycles.
- MUL: the multiplier runs `MUL_CYCLES` cycles after EXEC. `result_valid` is high after edge N+3+`MUL_CYCLES`, i.e. 19 cycles at default.
- `busy` rises after edge N and falls on the edge that leaves REPORT.
- The next strobe can be accepted in the cycle after `result_valid`.

## Configuration
- Macro: `MINI_CPU_MUL_EN`.
- Defined: MUL behaves as specified above.
- Undefined:
  - The multiplier is not instantiated.
  - Opcode 101 goes EXEC → REPORT with no register write.
  - It reports `result_dest = rd` and `result_value = 16'h0000`.
  - Latency is 3 cycles.

## Structure
- Shared package `mini_cpu_pkg` holds:
  - Opcode localparams `OP_LOAD` … `OP_DISPLAY`.
  - FSM state encoding.
  - Instruction field bit positions.
  - `DATA_W`.
- The LCD driver also uses the opcode constants from this package.
- One sub-module: `mini_cpu_mul`, an iterative shift-add multiplier.
  - Ports: `start`, `a`, `b`, `done`, `product`.
  - It is a `MUL_CYCLES`-cycle counter plus accumulator, clocked by `clk` and reset by `reset`.

## Test plan
- Reset with `power_en` = 1:
  - LOAD R3, +5 (`instr` = 18'b000_0011_00000000101) → valid 3 cycles later with op 0, dest 3, value 0x0005.
  - Then ADDI R4 = R3 + (−7) → value 0xFFFE, dest 4.
- MUL R5 = R3 × R4 → value 0xFFF6 exactly 19 cycles after the strobe.
  - Separately, LOAD 0x0100 into R1 and R2, then MUL → value 0x0000 (wraparound).
- A strobe during MUL_WAIT is dropped: exactly one valid pulse, and R6 is unchanged.
- CLEAR, then DISPLAY R3 → first pulse dest 0, value 0; second pulse dest 3, value 0x0000.
- `power_en` dropped during MUL_WAIT → no valid pulse, R5 keeps its old value, `busy` = 0 on the next cycle.
- `reset` asserted mid-EXEC → all outputs 0 and all registers 0 immediately.
- With `MINI_CPU_MUL_EN` undefined: MUL → value 0x0000 after 3 cycles, and `rd` is unchanged.
